req_capture: RTL and testbench

Front-end request capture stage feeding the priority encoder. Synchronises N asynchronous request lines, detects rising edges, and holds each event in a sticky pending bit until the downstream consumer acknowledges it by index. A mask register gates which pending bits are presented to the encoder. Sticky overrun flags record edges lost because a bit was already pending.

---
 rtl/req_capture.sv | 65 ++++++
 tb/tb_req_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_capture.sv
// Request capture front end: synchronises async request lines, latches rising
// edges into sticky pending bits cleared by indexed ack, and masks the encoder view.
module req_capture #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_in,
    input  logic          mask_wr,
    input  logic [N-1:0]  mask_in,
    input  logic          ack_valid,
    input  logic [IW-1:0] ack_idx,
    output logic [N-1:0]  pending,
    output logic          pend_any,
    output logic [N-1:0]  overrun,
    output logic [N-1:0]  mask_q
);

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] prev;
    logic [N-1:0] pending_q;
    logic [N-1:0] overrun_q;
    logic [N-1:0] rise;
    logic [N-1:0] ack_hit;

    // Indices at or beyond N never match a line, so out-of-range acks fall away.
    always_comb begin
        ack_hit = '0;
        for (int i = 0; i < N; i++) begin
            if (ack_valid && (ack_idx == IW'(i))) begin
                ack_hit[i] = 1'b1;
            end
        end
    end

    assign rise = sync2 & ~prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            mask_q    <= '1;
        end else begin
            sync1     <= req_in;
            sync2     <= sync1;
            prev      <= sync2;
            // A new edge outranks an ack on the same line, keeping the fresh event.
            pending_q <= rise | (pending_q & ~ack_hit);
            overrun_q <= (overrun_q & ~ack_hit) | (rise & pending_q & ~ack_hit);
            if (mask_wr) begin
                mask_q <= mask_in;
            end
        end
    end

    assign pending  = pending_q & mask_q;
    assign pend_any = |pending;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_req_capture.sv
// Bench for req_capture: vector table, directed multi-cycle sequences and a
// randomized run against a bit-vector reference model (N=8 and N=6 instances).
module tb_req_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in, mask_in, pending, overrun, mask_q;
    logic       mask_wr, ack_valid, pend_any;
    logic [2:0] ack_idx;

    logic [5:0] req6, mask_in6, pending6, overrun6, mask_q6;
    logic       mask_wr6, ack_valid6, pend_any6;
    logic [2:0] ack_idx6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    req_capture #(.N(8), .IW(3)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .mask_wr(mask_wr), .mask_in(mask_in),
        .ack_valid(ack_valid), .ack_idx(ack_idx), .pending(pending), .pend_any(pend_any),
        .overrun(overrun), .mask_q(mask_q)
    );

    req_capture #(.N(6), .IW(3)) dut6 (
        .clk(clk), .rst(rst), .req_in(req6), .mask_wr(mask_wr6), .mask_in(mask_in6),
        .ack_valid(ack_valid6), .ack_idx(ack_idx6), .pending(pending6), .pend_any(pend_any6),
        .overrun(overrun6), .mask_q(mask_q6)
    );

    typedef struct {
        logic [7:0] req;
        logic       mw;
        logic [7:0] mi;
        logic       av;
        logic [2:0] ai;
        logic [7:0] pend;
        logic [7:0] ov;
        logic [7:0] msk;
    } vec_t;

    vec_t tbl[15];

    // reference model state
    logic [7:0] m_pend, m_ov, m_mask, h1, h2, h3;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] r, input logic mw, input logic [7:0] mi,
                       input logic av, input logic [2:0] ai);
        req_in    = r;
        mask_wr   = mw;
        mask_in   = mi;
        ack_valid = av;
        ack_idx   = ai;
        @(posedge clk);
        #1;
        mask_wr   = 1'b0;
        ack_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, " rst pending"}, pending, 8'h00);
        chk({tag, " rst overrun"}, overrun, 8'h00);
        chk({tag, " rst mask_q"}, mask_q, 8'hFF);
        chk({tag, " rst pend_any"}, {7'b0, pend_any}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = '0; m_ov = '0; m_mask = '1; h1 = '0; h2 = '0; h3 = '0;
    endtask

    // One clock edge of the behaviour: an edge on a line becomes an event once
    // it has been seen for two sampled cycles after a low sample.
    task automatic model_step(input logic [7:0] r, input logic mw, input logic [7:0] mi,
                              input logic av, input logic [2:0] ai);
        logic [7:0] rise_m, ackm;
        rise_m = h2 & ~h3;
        ackm   = av ? (8'h01 << ai) : 8'h00;
        m_ov   = (m_ov & ~ackm) | (rise_m & m_pend & ~ackm);
        m_pend = rise_m | (m_pend & ~ackm);
        if (mw) m_mask = mi;
        h3 = h2; h2 = h1; h1 = r;
    endtask

    initial begin
        rst = 1'b1; req_in = '0; mask_wr = 0; mask_in = '0; ack_valid = 0; ack_idx = '0;
        req6 = '0; mask_wr6 = 0; mask_in6 = '0; ack_valid6 = 0; ack_idx6 = '0;

        // ---- reset with all lines high ----
        req_in = 8'hFF;
        do_reset("init");
        cyc(8'hFF, 0, 8'h00, 0, 3'd0);
        chk("rel edge1 pending", pending, 8'h00);
        cyc(8'hFF, 0, 8'h00, 0, 3'd0);
        chk("rel edge2 pending", pending, 8'h00);
        cyc(8'hFF, 0, 8'h00, 0, 3'd0);
        chk("rel edge3 pending", pending, 8'hFF);
        chk("rel edge3 pend_any", {7'b0, pend_any}, 8'h01);
        chk("rel edge3 mask_q", mask_q, 8'hFF);

        // ---- table: single event, ack, no re-assert, mask behaviour ----
        tbl[0]  = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF};
        tbl[1]  = '{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF};
        tbl[2]  = '{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF};
        tbl[3]  = '{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00, 8'hFF};
        tbl[4]  = '{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00, 8'hFF};
        tbl[5]  = '{8'h20, 1'b0, 8'h00, 1'b1, 3'd5, 8'h00, 8'h00, 8'hFF};
        tbl[6]  = '{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF};
        tbl[7]  = '{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF};
        tbl[8]  = '{8'h00, 1'b1, 8'h0F, 1'b0, 3'd0, 8'h00, 8'h00, 8'h0F};
        tbl[9]  = '{8'h82, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h0F};
        tbl[10] = '{8'h82, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h0F};
        tbl[11] = '{8'h82, 1'b0, 8'h00, 1'b0, 3'd0, 8'h02, 8'h00, 8'h0F};
        tbl[12] = '{8'h82, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h82, 8'h00, 8'hFF};
        tbl[13] = '{8'h82, 1'b0, 8'h00, 1'b1, 3'd7, 8'h02, 8'h00, 8'hFF};
        tbl[14] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 8'h00, 8'h00, 8'hFF};
        req_in = 8'h00;
        do_reset("tbl");
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].req, tbl[i].mw, tbl[i].mi, tbl[i].av, tbl[i].ai);
            chk($sformatf("vec%0d pending", i), pending, tbl[i].pend);
            chk($sformatf("vec%0d overrun", i), overrun, tbl[i].ov);
            chk($sformatf("vec%0d mask_q", i), mask_q, tbl[i].msk);
            chk($sformatf("vec%0d pend_any", i), {7'b0, pend_any}, {7'b0, |tbl[i].pend});
        end

        // ---- overrun on line 2 ----
        req_in = 8'h00;
        do_reset("ovr");
        repeat (3) cyc(8'h04, 0, 8'h00, 0, 3'd0);
        repeat (3) cyc(8'h00, 0, 8'h00, 0, 3'd0);
        repeat (2) cyc(8'h04, 0, 8'h00, 0, 3'd0);
        chk("ovr before 2nd edge overrun", overrun, 8'h00);
        chk("ovr before 2nd edge pending", pending, 8'h04);
        repeat (2) cyc(8'h04, 0, 8'h00, 0, 3'd0);
        chk("ovr set overrun", overrun, 8'h04);
        chk("ovr set pending", pending, 8'h04);
        cyc(8'h04, 0, 8'h00, 1, 3'd2);
        chk("ovr ack overrun", overrun, 8'h00);
        chk("ovr ack pending", pending, 8'h00);

        // ---- ack colliding with a new rise on line 0 ----
        req_in = 8'h00;
        do_reset("col");
        repeat (3) cyc(8'h01, 0, 8'h00, 0, 3'd0);
        repeat (3) cyc(8'h00, 0, 8'h00, 0, 3'd0);
        repeat (2) cyc(8'h01, 0, 8'h00, 0, 3'd0);
        cyc(8'h01, 0, 8'h00, 1, 3'd0);
        chk("col1 pending", pending, 8'h01);
        chk("col1 overrun", overrun, 8'h00);
        repeat (3) cyc(8'h00, 0, 8'h00, 0, 3'd0);
        repeat (3) cyc(8'h01, 0, 8'h00, 0, 3'd0);
        chk("col2 overrun set", overrun, 8'h01);
        repeat (3) cyc(8'h00, 0, 8'h00, 0, 3'd0);
        repeat (2) cyc(8'h01, 0, 8'h00, 0, 3'd0);
        cyc(8'h01, 0, 8'h00, 1, 3'd0);
        chk("col3 pending", pending, 8'h01);
        chk("col3 overrun cleared", overrun, 8'h00);

        // ---- N=6 instance: out-of-range acks, mask write plus ack ----
        req_in = 8'h00;
        do_reset("n6");
        req6 = 6'h3F;
        repeat (3) cyc(8'h00, 0, 8'h00, 0, 3'd0);
        chk("n6 pending all", {2'b0, pending6}, 8'h3F);
        ack_valid6 = 1'b1; ack_idx6 = 3'd7;
        cyc(8'h00, 0, 8'h00, 0, 3'd0);
        ack_valid6 = 1'b0;
        chk("n6 ack7 ignored", {2'b0, pending6}, 8'h3F);
        ack_valid6 = 1'b1; ack_idx6 = 3'd6;
        cyc(8'h00, 0, 8'h00, 0, 3'd0);
        ack_valid6 = 1'b0;
        chk("n6 ack6 ignored", {2'b0, pending6}, 8'h3F);
        ack_valid6 = 1'b1; ack_idx6 = 3'd0; mask_wr6 = 1'b1; mask_in6 = 6'h15;
        cyc(8'h00, 0, 8'h00, 0, 3'd0);
        ack_valid6 = 1'b0; mask_wr6 = 1'b0;
        chk("n6 mask+ack pending", {2'b0, pending6}, 8'h14);
        chk("n6 mask+ack mask_q", {2'b0, mask_q6}, 8'h15);
        mask_wr6 = 1'b1; mask_in6 = 6'h3F;
        cyc(8'h00, 0, 8'h00, 0, 3'd0);
        mask_wr6 = 1'b0;
        chk("n6 unmask pending", {2'b0, pending6}, 8'h3E);
        chk("n6 overrun", {2'b0, overrun6}, 8'h00);

        // ---- randomized run against the reference model ----
        req_in = 8'h00;
        do_reset("rnd");
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r, mi;
            logic       mw, av;
            logic [2:0] ai;
            if (i == 300) begin
                do_reset("rnd mid");
                model_reset();
            end
            r  = req_in ^ (8'($urandom) & 8'($urandom));
            mw = ($urandom_range(0, 9) == 0);
            mi = 8'($urandom);
            av = ($urandom_range(0, 2) == 0);
            ai = 3'($urandom_range(0, 7));
            model_step(r, mw, mi, av, ai);
            cyc(r, mw, mi, av, ai);
            chk($sformatf("rnd%0d pending", i), pending, m_pend & m_mask);
            chk($sformatf("rnd%0d overrun", i), overrun, m_ov);
            chk($sformatf("rnd%0d mask_q", i), mask_q, m_mask);
            chk($sformatf("rnd%0d pend_any", i), {7'b0, pend_any}, {7'b0, |(m_pend & m_mask)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
